// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and constants for the matrix-multiply sequencer
package mm_pkg;

    localparam int DIM_W_DEFAULT = 2;
    // Upper bound on DIM_W; matrix size fields are stored at this width.
    localparam int DIM_W_MAX = 8;

    typedef enum logic [2:0] {
        ST_LOAD_M1,
        ST_LOAD_M2,
        ST_CHECK,
        ST_MAC,
        ST_OUTPUT
    } state_t;

    typedef struct packed {
        logic [DIM_W_MAX-1:0] last_row;
        logic [DIM_W_MAX-1:0] last_col;
        logic                 malformed;
    } mat_info_t;

endpackage

// File: rtl/mm_idx_counter.sv
// rtl/mm_idx_counter.sv - index counter with clear, saturating increment and last-index compare
module mm_idx_counter
    import mm_pkg::*;
#(
    parameter int W = DIM_W_DEFAULT
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    input  logic [DIM_W_MAX-1:0] limit,
    output logic [W-1:0]         value,
    output logic                 is_last
);

    logic at_max;

    assign at_max  = &value;
    assign is_last = (DIM_W_MAX'(value) == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !at_max) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/mm_seq_ctrl.sv
// rtl/mm_seq_ctrl.sv - load, legality check and MAC sequencing for the matrix-multiply engine
module mm_seq_ctrl
    import mm_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             col_end,
    input  logic             row_end,
    input  logic             out_ready,
    output logic             M1_wen,
    output logic             M2_wen,
    output logic [DIM_W-1:0] wr_row,
    output logic [DIM_W-1:0] wr_col,
    output logic [DIM_W-1:0] rd_i,
    output logic [DIM_W-1:0] rd_k,
    output logic [DIM_W-1:0] rd_j,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             out_valid,
    output logic [DIM_W-1:0] out_row,
    output logic [DIM_W-1:0] out_col,
    output logic             is_legal,
    output logic             busy,
    output logic             done
);

    localparam logic [DIM_W_MAX-1:0] MAX_LIMIT = DIM_W_MAX'({DIM_W{1'b1}});

    state_t    state;
    mat_info_t m1, m2, cur, cur_nxt;
    logic      loading, load_wr, accept, final_beat, legal;
    logic      wr_col_max, wr_row_max, i_last, j_last, k_last;

    assign loading    = (state == ST_LOAD_M1) || (state == ST_LOAD_M2);
    assign load_wr    = loading && in_valid;
    assign M1_wen     = (state == ST_LOAD_M1) && in_valid;
    assign M2_wen     = (state == ST_LOAD_M2) && in_valid;
    assign busy       = !loading;
    assign acc_en     = (state == ST_MAC);
    assign acc_clr    = acc_en && (rd_k == '0);
    assign out_valid  = (state == ST_OUTPUT);
    assign out_row    = rd_i;
    assign out_col    = rd_j;
    assign accept     = out_valid && out_ready;
    assign final_beat = !is_legal || (i_last && j_last);
    assign done       = accept && final_beat;
    assign legal      = (m1.last_col == m2.last_row) && !m1.malformed && !m2.malformed;

    mm_idx_counter #(.W(DIM_W)) u_wr_col (
        .clk(clk), .rst(rst),
        .clr(load_wr && col_end),
        .inc(load_wr && !col_end),
        .limit(MAX_LIMIT),
        .value(wr_col), .is_last(wr_col_max)
    );

    mm_idx_counter #(.W(DIM_W)) u_wr_row (
        .clk(clk), .rst(rst),
        .clr(load_wr && col_end && row_end),
        .inc(load_wr && col_end && !row_end),
        .limit(MAX_LIMIT),
        .value(wr_row), .is_last(wr_row_max)
    );

    mm_idx_counter #(.W(DIM_W)) u_k (
        .clk(clk), .rst(rst),
        .clr((acc_en && k_last) || (state == ST_CHECK)),
        .inc(acc_en && !k_last),
        .limit(m1.last_col),
        .value(rd_k), .is_last(k_last)
    );

    mm_idx_counter #(.W(DIM_W)) u_j (
        .clk(clk), .rst(rst),
        .clr((accept && j_last) || (state == ST_CHECK)),
        .inc(accept && is_legal && !j_last),
        .limit(m2.last_col),
        .value(rd_j), .is_last(j_last)
    );

    mm_idx_counter #(.W(DIM_W)) u_i (
        .clk(clk), .rst(rst),
        .clr((accept && j_last && i_last) || (state == ST_CHECK)),
        .inc(accept && is_legal && j_last && !i_last),
        .limit(m1.last_row),
        .value(rd_i), .is_last(i_last)
    );

    // Shape tracking for whichever matrix is loading; the first row defines the width.
    always_comb begin
        cur     = (state == ST_LOAD_M2) ? m2 : m1;
        cur_nxt = cur;
        if (load_wr) begin
            if (!col_end) begin
                if (wr_col_max) cur_nxt.malformed = 1'b1;
            end else begin
                if (wr_row == '0) begin
                    cur_nxt.last_col = DIM_W_MAX'(wr_col);
                end else if (DIM_W_MAX'(wr_col) != cur.last_col) begin
                    cur_nxt.malformed = 1'b1;
                end
                if (row_end) begin
                    cur_nxt.last_row = DIM_W_MAX'(wr_row);
                end else if (wr_row_max) begin
                    cur_nxt.malformed = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_LOAD_M1;
            m1       <= '0;
            m2       <= '0;
            is_legal <= 1'b0;
        end else begin
            case (state)
                ST_LOAD_M1: begin
                    m1 <= cur_nxt;
                    if (load_wr && col_end && row_end) state <= ST_LOAD_M2;
                end
                ST_LOAD_M2: begin
                    m2 <= cur_nxt;
                    if (load_wr && col_end && row_end) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    is_legal <= legal;
                    state    <= legal ? ST_MAC : ST_OUTPUT;
                end
                ST_MAC: begin
                    if (k_last) state <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (accept) begin
                        if (final_beat) begin
                            state <= ST_LOAD_M1;
                            m1    <= '0;
                            m2    <= '0;
                        end else begin
                            state <= ST_MAC;
                        end
                    end
                end
                default: state <= ST_LOAD_M1;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb/tb_mm_seq_ctrl.sv - scoreboard bench for mm_seq_ctrl
module tb_mm_seq_ctrl;

    localparam int DIM_W = 2;
    localparam int MAXI  = (1 << DIM_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             col_end = 1'b0;
    logic             row_end = 1'b0;
    logic             out_ready = 1'b1;
    logic             M1_wen, M2_wen, acc_clr, acc_en, out_valid, is_legal, busy, done;
    logic [DIM_W-1:0] wr_row, wr_col, rd_i, rd_k, rd_j, out_row, out_col;

    mm_seq_ctrl #(.DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .col_end(col_end), .row_end(row_end),
        .out_ready(out_ready), .M1_wen(M1_wen), .M2_wen(M2_wen), .wr_row(wr_row),
        .wr_col(wr_col), .rd_i(rd_i), .rd_k(rd_k), .rd_j(rd_j), .acc_clr(acc_clr),
        .acc_en(acc_en), .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
        .is_legal(is_legal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int legal;
        int done;
        int macs;
        int clrs;
        int vcyc;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    int   n_mac, n_clr, n_vld, prev_row, prev_col;
    logic prev_stall;

    // Monitor: per-beat MAC/clear/valid-cycle counts and handshake stability.
    always @(negedge clk) begin
        if (rst) begin
            n_mac      <= 0;
            n_clr      <= 0;
            n_vld      <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (busy) check("wen_while_busy", int'(M1_wen | M2_wen), 0);
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_row", int'(out_row), prev_row);
                check("hold_col", int'(out_col), prev_col);
            end
            if (out_valid) check("acc_en_in_output", int'(acc_en), 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got row %0d col %0d, expected no beat", out_row, out_col);
                end else begin
                    check("beat_row", int'(out_row), sb[0].row);
                    check("beat_col", int'(out_col), sb[0].col);
                    check("beat_legal", int'(is_legal), sb[0].legal);
                    check("beat_done", int'(done), sb[0].done);
                    check("beat_macs", n_mac, sb[0].macs);
                    check("beat_clrs", n_clr, sb[0].clrs);
                    check("beat_vcyc", n_vld + 1, sb[0].vcyc);
                    void'(sb.pop_front());
                end
                n_mac <= 0;
                n_clr <= 0;
                n_vld <= 0;
            end else begin
                check("done_idle", int'(done), 0);
                n_mac <= n_mac + int'(acc_en);
                n_clr <= n_clr + int'(acc_clr);
                n_vld <= n_vld + int'(out_valid);
            end
            prev_stall <= out_valid && !out_ready;
            prev_row   <= int'(out_row);
            prev_col   <= int'(out_col);
        end
    end

    task automatic send_elem(int mat, int r, int c, bit ce, bit re);
        in_valid = 1'b1;
        col_end  = ce;
        row_end  = re;
        @(negedge clk);
        check("wen_m1", int'(M1_wen), int'(mat == 1));
        check("wen_m2", int'(M2_wen), int'(mat == 2));
        check("wr_row", int'(wr_row), (r > MAXI) ? MAXI : r);
        check("wr_col", int'(wr_col), (c > MAXI) ? MAXI : c);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        col_end  = 1'b0;
        row_end  = 1'b0;
    endtask

    task automatic send_matrix(int mat, int rows, int len0, int len);
        for (int r = 0; r < rows; r++) begin
            int n;
            n = (r == 0) ? len0 : len;
            for (int c = 0; c < n; c++) begin
                send_elem(mat, r, c, c == n - 1, (c == n - 1) && (r == rows - 1));
            end
        end
    endtask

    // Idle in_valid noise is driven while busy; it must be ignored.
    task automatic run_job(string name, int m1r, int m1c0, int m1c, int m2r, int m2c,
                           bit legal, int stall_n);
        int cyc;
        int stalls;
        bit got_done;
        cyc = 0;
        stalls = 0;
        got_done = 1'b0;
        if (legal) begin
            for (int i = 0; i < m1r; i++) begin
                for (int j = 0; j < m2c; j++) begin
                    sb.push_back('{i, j, 1, int'(i == m1r - 1 && j == m2c - 1), m1c, 1,
                                   (i == 0 && j == 1) ? stall_n + 1 : 1});
                end
            end
        end else begin
            sb.push_back('{0, 0, 0, 1, 0, 0, 1});
        end
        send_matrix(1, m1r, m1c0, m1c);
        send_matrix(2, m2r, m2c, m2c);
        for (int t = 0; t < 400 && !got_done; t++) begin
            in_valid  = busy && !out_valid;
            col_end   = in_valid;
            row_end   = in_valid;
            out_ready = 1'b1;
            if (out_valid && out_row == 0 && out_col == 1 && stalls < stall_n) begin
                out_ready = 1'b0;
                stalls++;
            end
            @(negedge clk);
            if (busy) cyc++;
            if (done) got_done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        col_end   = 1'b0;
        row_end   = 1'b0;
        out_ready = 1'b1;
        check({name, "_done"}, int'(got_done), 1);
        check({name, "_cycles"}, cyc, legal ? 1 + m1r * m2c * (m1c + 1) + stall_n : 2);
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_idle"}, int'(busy), 0);
        sb.delete();
    endtask

    function automatic int all_outputs();
        return int'({M1_wen, M2_wen, wr_row, wr_col, rd_i, rd_k, rd_j, acc_clr, acc_en,
                     out_valid, out_row, out_col, is_legal, busy, done});
    endfunction

    initial begin
        bit found;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_job("j2x3x2", 2, 3, 3, 3, 2, 1'b1, 0);
        run_job("j1x1", 1, 1, 1, 1, 1, 1'b1, 0);
        run_job("j4x4", 4, 4, 4, 4, 4, 1'b1, 0);
        run_job("dim_mismatch", 2, 3, 3, 2, 2, 1'b0, 0);
        run_job("ragged", 2, 3, 2, 3, 2, 1'b0, 0);
        run_job("col_ovf", 1, 5, 5, 4, 1, 1'b0, 0);
        run_job("row_ovf", 5, 1, 1, 1, 1, 1'b0, 0);
        run_job("stall", 2, 2, 2, 2, 2, 1'b1, 3);

        send_matrix(1, 2, 2, 2);
        send_matrix(2, 2, 2, 2);
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (acc_en) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("rst_reached_mac", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_outputs", all_outputs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_job("after_rst", 1, 1, 1, 1, 1, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/mm_seq_ctrl.md
# mm_seq_ctrl

Parametrised sequencing controller for the matrix-multiply engine. It accepts two row-major element streams (M1, then M2) into the matrix buffers and captures each matrix's dimensions. It checks legality, then steps the MAC datapath through every output element. Results leave through a valid/ready handshake, so a downstream stall holds the engine. It sits between the input stream, the two matrix buffers and the accumulator/output stage.

## Interface
- DIM_W, default 2: index width; maximum matrix dimension is 2**DIM_W (default 4x4).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input element present this cycle.
- col_end  in  1  qualifies in_valid; element is last of its row.
- row_end  in  1  sampled only with in_valid&col_end; element is last of its matrix.
- out_ready  in  1  downstream accepts the current output beat.
- M1_wen / M2_wen  out  1  buffer write enable; equals in_valid in LOAD_M1 / LOAD_M2, else 0.
- wr_row, wr_col  out  DIM_W  write address of the current input element.
- rd_i, rd_k, rd_j  out  DIM_W  read addresses: M1[rd_i][rd_k], M2[rd_k][rd_j].
- acc_clr  out  1  MAC cycle with rd_k==0; accumulator loads product instead of adding.
- acc_en  out  1  MAC cycle active.
- out_valid  out  1  output beat pending.
- out_row, out_col  out  DIM_W  index of the current output element (= rd_i, rd_j).
- is_legal  out  1  dimensions compatible and both matrices well-formed; meaningful while out_valid.
- busy  out  1  state not LOAD_M1/LOAD_M2; upstream must not drive in_valid.
- done  out  1  one-cycle pulse on the final accepted beat (legal or illegal).

## Operation
- States: LOAD_M1, LOAD_M2, CHECK, MAC, OUTPUT. Reset state LOAD_M1.
- LOAD_Mx: each in_valid writes at (wr_row, wr_col). Without col_end, wr_col+1. With col_end, wr_col->0 and wr_row+1. The first row's col_end records last_col. in_valid&col_end&row_end records last_row, clears the write counters and moves LOAD_M1->LOAD_M2->CHECK.
- Malformed flag (per matrix, sticky until the next LOAD_M1 entry):
  - a later row's col_end arrives at a wr_col different from last_col;
  - wr_col==2**DIM_W-1 without col_end (the counter holds; the write is still issued);
  - wr_row==2**DIM_W-1 with col_end but without row_end (the counter holds).
- CHECK (1 cycle): legal = M1.last_col==M2.last_row and neither matrix malformed. Legal -> MAC with i=j=k=0. Illegal -> OUTPUT with is_legal=0.
- MAC: one cycle per k, 0..M1.last_col; acc_en=1. k==last -> OUTPUT.
- OUTPUT: out_valid=1; outputs stay stable until out_ready.
  - Illegal beat accepted -> done, LOAD_M1.
  - Legal beat accepted: j==M2.last_col and i==M1.last_row -> done, LOAD_M1. j==M2.last_col otherwise -> j=0, i+1, MAC. Else j+1, MAC. k resets to 0 in all cases.
- Sizes are stored as last index (DIM_W bits), so a full 2**DIM_W dimension needs no extra bit. No modular wrap is used.

## Timing
- Reset: state LOAD_M1. All counters, size registers and flags 0. All outputs 0 (is_legal 0).
- Write enables are combinational from in_valid; addresses are registered counters (zero write latency).
- Read addresses are registered; buffer reads are combinational, and the accumulator updates on the edge ending each MAC cycle.
- Legal job with out_ready held 1: CHECK 1 cycle, then M*N*(K+1) cycles, where M=M1 rows, K=M1 cols, N=M2 cols. Stall cycles add 1:1.
- out_valid rises the cycle after the last MAC cycle. It never drops without out_ready.
- in_valid while busy is ignored: no write, no counter change.
- rst asserted mid-job aborts immediately. Buffer contents are don't-care; the next job starts at LOAD_M1.

## Structure
- Shared package mm_pkg holds:
  - the state enum;
  - the default DIM_W;
  - a struct {last_row, last_col, malformed} per matrix.
- One sub-module: mm_idx_counter (DIM_W-bit counter with inc, clr, hold-at-max and is_last compare against a limit). It is instantiated for write row/col and for i/j/k.

## Test plan
- 2x3 * 3x2, out_ready=1 -> CHECK 1 cycle; 4 beats (0,0),(0,1),(1,0),(1,1); 3 MAC cycles each with acc_clr on k=0; done on the 4th beat; 16 cycles from CHECK exit.
- 1x1 * 1x1 -> one MAC cycle with acc_clr=acc_en=1; one beat (0,0) with is_legal=1; done.
- 4x4 * 4x4 at DIM_W=2 -> no malformed flag; 16 beats; last beat (3,3); 80 cycles.
- 2x3 * 2x2 -> CHECK to OUTPUT with no MAC cycles; single beat is_legal=0; done; back in LOAD_M1.
- Legal 2x2*2x2 with out_ready low for 3 cycles on beat (0,1) -> out_valid, out_row=0, out_col=1 held 4 cycles; acc_en=0 during the stall.
- M1 rows of lengths 3 then 2 -> single illegal beat. Separately, rst pulsed during MAC -> all outputs 0 next cycle; a fresh 1x1 job then completes correctly.
